// File: rtl/wb_pkg.sv
// Shared types for the Wishbone stream bridge.
// Holds the FSM state encoding, response codes and wait-counter width.
package wb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } wb_state_t;

  typedef enum logic [1:0] {
    NONE,
    ACK,
    ERR,
    RTY
  } wb_resp_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy.
// The head entry is visible combinationally.
module sync_fifo #(
  parameter int DAT_WIDTH = 8,
  parameter int DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DAT_WIDTH-1:0]         push_data,
  output logic [DAT_WIDTH-1:0]         head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [DAT_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wptr;
  logic [PTR_W-1:0]     rptr;
  logic [LVL_W-1:0]     count;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == LVL_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];
  assign level   = count;

  // Storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (do_pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_stream_bridge_device.sv
// Wishbone classic device: writes feed a TX stream FIFO, reads drain an RX
// stream FIFO, with registered one-hot responses and optional wait states.
module wb_stream_bridge_device
  import wb_pkg::*;
#(
  parameter int DAT_WIDTH      = 8,
  parameter int DEPTH          = 4,
  parameter int WAIT_STATES    = 0,
  parameter bit RETRY_ON_STALL = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cyc_i,
  input  logic                       stb_i,
  input  logic                       we_i,
  input  logic [DAT_WIDTH-1:0]       dat_i,
  output logic                       ack_o,
  output logic                       err_o,
  output logic                       rty_o,
  output logic [DAT_WIDTH-1:0]       dat_o,
  output logic [DAT_WIDTH-1:0]       tx_data_o,
  output logic                       tx_valid_o,
  input  logic                       tx_ready_i,
  input  logic [DAT_WIDTH-1:0]       rx_data_i,
  input  logic                       rx_valid_i,
  output logic                       rx_ready_o,
  output logic [$clog2(DEPTH+1)-1:0] tx_level_o,
  output logic [$clog2(DEPTH+1)-1:0] rx_level_o
);

  wb_state_t            state_q;
  wb_state_t            state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  wb_resp_t             resp_q;
  wb_resp_t             resp_d;
  logic                 req;
  logic                 commit;
  logic                 xfer_ok;

  logic                 tx_full;
  logic                 tx_empty;
  logic                 tx_push;
  logic                 tx_pop;
  logic                 rx_full;
  logic                 rx_empty;
  logic                 rx_push;
  logic                 rx_pop;
  logic [DAT_WIDTH-1:0] rx_head;

  assign req = cyc_i && stb_i;

  // Stall decisions use pre-edge occupancy; no same-edge bypass.
  assign xfer_ok = we_i ? !tx_full : !rx_empty;
  assign tx_push = commit && we_i && !tx_full;
  assign rx_pop  = commit && !we_i && !rx_empty;

  assign tx_valid_o = !tx_empty;
  assign tx_pop     = tx_valid_o && tx_ready_i;
  assign rx_ready_o = !rx_full;
  assign rx_push    = rx_valid_i && rx_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      resp_q  <= NONE;
      dat_o   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      if (rx_pop) begin
        dat_o <= rx_head;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_STATES);
          end
        end
      end
      WAIT: begin
        if (!cyc_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          cnt_d   = '0;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    resp_d = NONE;
    if (commit) begin
      if (xfer_ok) begin
        resp_d = ACK;
      end else if (RETRY_ON_STALL) begin
        resp_d = RTY;
      end else begin
        resp_d = ERR;
      end
    end
  end

  always_comb begin
    ack_o = (resp_q == ACK);
    err_o = (resp_q == ERR);
    rty_o = (resp_q == RTY);
  end

  sync_fifo #(
    .DAT_WIDTH (DAT_WIDTH),
    .DEPTH     (DEPTH)
  ) u_tx_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (tx_push),
    .pop       (tx_pop),
    .push_data (dat_i),
    .head      (tx_data_o),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level_o)
  );

  sync_fifo #(
    .DAT_WIDTH (DAT_WIDTH),
    .DEPTH     (DEPTH)
  ) u_rx_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (rx_push),
    .pop       (rx_pop),
    .push_data (rx_data_i),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level_o)
  );

endmodule

// File: tb/tb_wb_stream_bridge_device.sv
// Directed bench: three bridge instances with WAIT_STATES 0/2/3,
// the last one answering stalls with err.
module tb_wb_stream_bridge_device;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       cyc      [3];
  logic       stb      [3];
  logic       we       [3];
  logic [7:0] wdat     [3];
  logic       ack      [3];
  logic       err      [3];
  logic       rty      [3];
  logic [7:0] rdat     [3];
  logic [7:0] tx_data  [3];
  logic       tx_valid [3];
  logic       tx_ready [3];
  logic [7:0] rx_data  [3];
  logic       rx_valid [3];
  logic       rx_ready [3];
  logic [2:0] tx_level [3];
  logic [2:0] rx_level [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wb_stream_bridge_device #(
      .DAT_WIDTH      (8),
      .DEPTH          (4),
      .WAIT_STATES    ((g == 0) ? 0 : (g == 1) ? 2 : 3),
      .RETRY_ON_STALL ((g == 2) ? 1'b0 : 1'b1)
    ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .cyc_i      (cyc[g]),
      .stb_i      (stb[g]),
      .we_i       (we[g]),
      .dat_i      (wdat[g]),
      .ack_o      (ack[g]),
      .err_o      (err[g]),
      .rty_o      (rty[g]),
      .dat_o      (rdat[g]),
      .tx_data_o  (tx_data[g]),
      .tx_valid_o (tx_valid[g]),
      .tx_ready_i (tx_ready[g]),
      .rx_data_i  (rx_data[g]),
      .rx_valid_i (rx_valid[g]),
      .rx_ready_o (rx_ready[g]),
      .tx_level_o (tx_level[g]),
      .rx_level_o (rx_level[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] resp_of(input int d);
    return {ack[d], err[d], rty[d]};
  endfunction

  // Issue one transfer, wait for any response, check code and latency.
  task automatic xfer(input int d, input bit w, input logic [7:0] v,
                      input logic [2:0] exp_r, input int exp_lat,
                      input string tag);
    int n = 0;
    logic [2:0] r = 3'b000;
    cyc[d]  = 1'b1;
    stb[d]  = 1'b1;
    we[d]   = w;
    wdat[d] = v;
    while (r == 3'b000 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      r = resp_of(d);
    end
    cyc[d] = 1'b0;
    stb[d] = 1'b0;
    we[d]  = 1'b0;
    check({tag, "_resp"}, 32'(r), 32'(exp_r));
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(resp_of(d)), 32'd0);
  endtask

  task automatic rx_push(input int d, input logic [7:0] v);
    rx_data[d]  = v;
    rx_valid[d] = 1'b1;
    @(posedge clk);
    #1;
    rx_valid[d] = 1'b0;
  endtask

  task automatic quiet(input int d, input int cycles, input string tag);
    int hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (resp_of(d) != 3'b000) hits++;
    end
    check(tag, 32'(hits), 32'd0);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      cyc[d] = 0; stb[d] = 0; we[d] = 0; wdat[d] = 0;
      tx_ready[d] = 0; rx_data[d] = 0; rx_valid[d] = 0;
    end
    #12;
    check("rst_resp", 32'(resp_of(0)), 32'd0);
    check("rst_dat", 32'(rdat[0]), 32'd0);
    check("rst_txv", 32'(tx_valid[0]), 32'd0);
    check("rst_rxr", 32'(rx_ready[0]), 32'd1);
    check("rst_lvl", 32'({tx_level[0], rx_level[0]}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // TX write path, zero wait states
    xfer(0, 1'b1, 8'hA5, 3'b100, 1, "tx_wr");
    check("tx_wr_lvl", 32'(tx_level[0]), 32'd1);
    check("tx_wr_vld", 32'(tx_valid[0]), 32'd1);
    check("tx_wr_dat", 32'(tx_data[0]), 32'hA5);
    tx_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    tx_ready[0] = 1'b0;
    check("tx_drain", 32'({tx_valid[0], tx_level[0]}), 32'd0);

    // TX full: fifth write is retried
    for (int i = 1; i <= 5; i++) begin
      xfer(0, 1'b1, 8'(i), (i == 5) ? 3'b001 : 3'b100, 1, "tx_full");
      check("tx_full_lvl", 32'(tx_level[0]), 32'((i > 4) ? 4 : i));
    end
    tx_ready[0] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("tx_strm_vld", 32'(tx_valid[0]), 32'd1);
      check("tx_strm_dat", 32'(tx_data[0]), 32'(i));
      @(posedge clk);
      #1;
    end
    tx_ready[0] = 1'b0;
    check("tx_strm_end", 32'(tx_valid[0]), 32'd0);

    // RX read with two wait states
    rx_push(1, 8'h3C);
    check("rx_in_lvl", 32'(rx_level[1]), 32'd1);
    xfer(1, 1'b0, 8'h00, 3'b100, 3, "rx_rd");
    check("rx_rd_dat", 32'(rdat[1]), 32'h3C);
    check("rx_rd_lvl", 32'(rx_level[1]), 32'd0);
    xfer(1, 1'b0, 8'h00, 3'b001, 3, "rx_empty");
    check("rx_empty_dat", 32'(rdat[1]), 32'h3C);

    // Error mode: empty read answered with err
    xfer(2, 1'b0, 8'h00, 3'b010, 4, "err_rd");
    check("err_rd_dat", 32'(rdat[2]), 32'd0);

    // Abort after one wait cycle
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; wdat[2] = 8'h77;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
    quiet(2, 6, "abort_quiet");
    check("abort_lvl", 32'(tx_level[2]), 32'd0);
    xfer(2, 1'b1, 8'h55, 3'b100, 4, "post_abort");
    check("post_abort_lvl", 32'(tx_level[2]), 32'd1);
    check("post_abort_dat", 32'(tx_data[2]), 32'h55);

    // Same-edge RX push and bus pop on a 1-entry FIFO
    rx_push(0, 8'h11);
    check("sim_pre_lvl", 32'(rx_level[0]), 32'd1);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0;
    rx_data[0] = 8'h22; rx_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    rx_valid[0] = 1'b0;
    cyc[0] = 1'b0; stb[0] = 1'b0;
    check("sim_resp", 32'(resp_of(0)), 32'b100);
    check("sim_dat", 32'(rdat[0]), 32'h11);
    check("sim_lvl", 32'(rx_level[0]), 32'd1);
    @(posedge clk);
    #1;
    xfer(0, 1'b0, 8'h00, 3'b100, 1, "sim_rd2");
    check("sim_rd2_dat", 32'(rdat[0]), 32'h22);
    check("sim_rd2_lvl", 32'(rx_level[0]), 32'd0);

    // Reset in the middle of a WAIT
    rx_push(1, 8'h44);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_resp", 32'(resp_of(1)), 32'd0);
    check("mid_rst_dat", 32'(rdat[1]), 32'd0);
    check("mid_rst_rxl", 32'(rx_level[1]), 32'd0);
    check("mid_rst_rxr", 32'(rx_ready[1]), 32'd1);
    check("mid_rst_txl", 32'({tx_valid[2], tx_level[2]}), 32'd0);
    check("mid_rst_dat0", 32'(rdat[0]), 32'd0);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    quiet(1, 6, "mid_rst_quiet");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
